rhs_zcheck_sweep: RTL and testbench

RHS_ZCHECK_SWEEP -- requirements
Module: rhs_zcheck_sweep

---
 rtl/rhs_zcheck_sweep_if.sv | 26 ++
 rtl/rhs_zcheck_sweep.sv | 174 +++++++++++++++++
 tb/tb_rhs_zcheck_sweep.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rhs_zcheck_sweep_if.sv
// rtl/rhs_zcheck_sweep_if.sv - zcheck request/completion handshake between the sweep sequencer and rhs_256
//   zcheck_start          1-cycle start pulse to the engine
//   zcheck_global_channel channel to measure
//   zcheck_scale          impedance-check scale
//   zcheck_done           1-cycle completion pulse from the engine
//   master: sweep sequencer side, slave: rhs_256 side
interface rhs_zcheck_sweep_if;
    logic        zcheck_start;
    logic [11:0] zcheck_global_channel;
    logic [1:0]  zcheck_scale;
    logic        zcheck_done;

    modport master (
        output zcheck_start,
        output zcheck_global_channel,
        output zcheck_scale,
        input  zcheck_done
    );

    modport slave (
        input  zcheck_start,
        input  zcheck_global_channel,
        input  zcheck_scale,
        output zcheck_done
    );
endinterface

// File: rtl/rhs_zcheck_sweep.sv
// rtl/rhs_zcheck_sweep.sv - sequences rhs_256 impedance checks over a channel range
//   clk, rstn                     clock, asynchronous active-low reset
//   sweep_start, sweep_abort      level controls
//   first_channel, last_channel   inclusive channel range (0..255)
//   scale_cfg                     scale when the scale sweep is compiled out
//   settle_cycles                 idle gap after each measurement
//   timeout_cycles                zcheck_done wait limit, 0 = no limit
//   zc                            engine handshake (master modport)
//   busy, sweep_done, result_valid, result_channel, result_scale, range_err, timeout_err
//   Macro ZCHECK_SCALE_SWEEP_EN: measure every channel at scales 00, 01, 11.
module rhs_zcheck_sweep (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sweep_start,
    input  logic                 sweep_abort,
    input  logic [11:0]          first_channel,
    input  logic [11:0]          last_channel,
    input  logic [1:0]           scale_cfg,
    input  logic [15:0]          settle_cycles,
    input  logic [23:0]          timeout_cycles,
    rhs_zcheck_sweep_if.master   zc,
    output logic                 busy,
    output logic                 sweep_done,
    output logic                 result_valid,
    output logic [11:0]          result_channel,
    output logic [1:0]           result_scale,
    output logic                 range_err,
    output logic                 timeout_err
);
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, SETTLE, NEXT} state_t;

    state_t      state;
    logic [11:0] last_q;
    logic [15:0] settle_q;
    logic [23:0] tmo_q;
    logic [23:0] tcnt;
    logic [15:0] scnt;
    logic        start_q;
    logic [11:0] chan_q;
    logic [1:0]  scale_q;

    logic        range_ok;
    logic        last_scale;
    logic [1:0]  init_scale;
    logic [1:0]  restart_scale;
    logic [1:0]  next_scale;

    assign range_ok = (first_channel <= last_channel) && (last_channel <= 12'd255);

`ifdef ZCHECK_SCALE_SWEEP_EN
    // Scale order is 00 -> 01 -> 11; 10 is never visited.
    logic unused_scale_cfg;
    assign unused_scale_cfg = ^scale_cfg;
    assign init_scale    = 2'b00;
    assign restart_scale = 2'b00;
    assign last_scale    = (scale_q == 2'b11);
    assign next_scale    = (scale_q == 2'b00) ? 2'b01 : 2'b11;
`else
    // One measurement per channel at the scale captured on acceptance.
    assign init_scale    = scale_cfg;
    assign restart_scale = scale_q;
    assign last_scale    = 1'b1;
    assign next_scale    = scale_q;
`endif

    assign zc.zcheck_start          = start_q;
    assign zc.zcheck_global_channel = chan_q;
    assign zc.zcheck_scale          = scale_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            last_q         <= '0;
            settle_q       <= '0;
            tmo_q          <= '0;
            tcnt           <= '0;
            scnt           <= '0;
            start_q        <= 1'b0;
            chan_q         <= '0;
            scale_q        <= '0;
            busy           <= 1'b0;
            sweep_done     <= 1'b0;
            result_valid   <= 1'b0;
            result_channel <= '0;
            result_scale   <= '0;
            range_err      <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            start_q      <= 1'b0;
            sweep_done   <= 1'b0;
            result_valid <= 1'b0;
            if (state != IDLE && sweep_abort) begin
                // Abort beats any simultaneous done; quiet return, no status.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sweep_start && !sweep_abort) begin
                            if (range_ok) begin
                                state       <= LOAD;
                                busy        <= 1'b1;
                                range_err   <= 1'b0;
                                timeout_err <= 1'b0;
                                chan_q      <= first_channel;
                                scale_q     <= init_scale;
                                last_q      <= last_channel;
                                settle_q    <= settle_cycles;
                                tmo_q       <= timeout_cycles;
                            end else begin
                                sweep_done <= 1'b1;
                                range_err  <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        start_q <= 1'b1;
                        state   <= START;
                    end
                    START: begin
                        // Counter holds cycles elapsed since the start pulse.
                        tcnt  <= 24'd1;
                        state <= WAIT_DONE;
                    end
                    WAIT_DONE: begin
                        if (zc.zcheck_done) begin
                            result_valid   <= 1'b1;
                            result_channel <= chan_q;
                            result_scale   <= scale_q;
                            scnt           <= '0;
                            state          <= SETTLE;
                        end else if (tmo_q != 24'd0 &&
                                     ({1'b0, tcnt} + 25'd1 >= {1'b0, tmo_q})) begin
                            timeout_err <= 1'b1;
                            sweep_done  <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            tcnt <= tcnt + 24'd1;
                        end
                    end
                    SETTLE: begin
                        // Gap of settle_q cycles, at least one.
                        if ({1'b0, scnt} + 17'd1 >= {1'b0, settle_q}) begin
                            state <= NEXT;
                        end else begin
                            scnt <= scnt + 16'd1;
                        end
                    end
                    NEXT: begin
                        if (!last_scale) begin
                            scale_q <= next_scale;
                            start_q <= 1'b1;
                            state   <= START;
                        end else if (chan_q != last_q) begin
                            chan_q  <= chan_q + 12'd1;
                            scale_q <= restart_scale;
                            start_q <= 1'b1;
                            state   <= START;
                        end else begin
                            sweep_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rhs_zcheck_sweep.sv
// tb/tb_rhs_zcheck_sweep.sv - self-checking bench for rhs_zcheck_sweep
module tb_rhs_zcheck_sweep;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        sweep_start;
    logic        sweep_abort;
    logic [11:0] first_channel;
    logic [11:0] last_channel;
    logic [1:0]  scale_cfg;
    logic [15:0] settle_cycles;
    logic [23:0] timeout_cycles;
    logic        busy;
    logic        sweep_done;
    logic        result_valid;
    logic [11:0] result_channel;
    logic [1:0]  result_scale;
    logic        range_err;
    logic        timeout_err;

    rhs_zcheck_sweep_if zc();

    rhs_zcheck_sweep dut (
        .clk            (clk),
        .rstn           (rstn),
        .sweep_start    (sweep_start),
        .sweep_abort    (sweep_abort),
        .first_channel  (first_channel),
        .last_channel   (last_channel),
        .scale_cfg      (scale_cfg),
        .settle_cycles  (settle_cycles),
        .timeout_cycles (timeout_cycles),
        .zc             (zc),
        .busy           (busy),
        .sweep_done     (sweep_done),
        .result_valid   (result_valid),
        .result_channel (result_channel),
        .result_scale   (result_scale),
        .range_err      (range_err),
        .timeout_err    (timeout_err)
    );

    typedef struct packed {
        logic [11:0] ch;
        logic [1:0]  sc;
    } meas_t;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},        busy, 0);
        check({tag, "_sweep_done"},  sweep_done, 0);
        check({tag, "_result_valid"},result_valid, 0);
        check({tag, "_result_chan"}, result_channel, 0);
        check({tag, "_result_scale"},result_scale, 0);
        check({tag, "_range_err"},   range_err, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_zstart"},      zc.zcheck_start, 0);
        check({tag, "_zchan"},       zc.zcheck_global_channel, 0);
        check({tag, "_zscale"},      zc.zcheck_scale, 0);
    endtask

    // delay: start-to-done cycles; 0 = random 1..12; -1 = engine never answers.
    // abort_ch: abort in the settle gap after this channel's result (-1 = none).
    task automatic run_sweep(input int first, input int last, input int settle, input int tmo,
                             input logic [1:0] scale, input int delay, input int abort_ch,
                             input bit noise);
        meas_t      q[$];
        meas_t      cur;
        meas_t      m;
        logic [1:0] sl[$];
        int cyc, exp_start, done_at, exp_rv, exp_sd, end_cyc, abort_at, nxt;
        bit exp_tmo;
`ifdef ZCHECK_SCALE_SWEEP_EN
        sl = '{2'b00, 2'b01, 2'b11};
`else
        sl = '{scale};
`endif
        for (int c = first; c <= last; c++) begin
            foreach (sl[i]) begin
                m.ch = c[11:0];
                m.sc = sl[i];
                q.push_back(m);
            end
        end

        @(negedge clk);
        first_channel  = first[11:0];
        last_channel   = last[11:0];
        settle_cycles  = settle[15:0];
        timeout_cycles = tmo[23:0];
        scale_cfg      = scale;
        sweep_start    = 1'b1;
        @(posedge clk);
        #1;
        sweep_start    = 1'b0;
        // Changes after acceptance must not reach the running sweep.
        first_channel  = 12'($urandom);
        last_channel   = 12'($urandom);
        settle_cycles  = 16'($urandom);
        timeout_cycles = 24'($urandom_range(1, 3));
        scale_cfg      = 2'($urandom);

        exp_start = 1; done_at = -1; exp_rv = -1; exp_sd = -1;
        end_cyc = -1; abort_at = -1; exp_tmo = 1'b0; cur = '0;
        for (cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            check("zstart", zc.zcheck_start, cyc == exp_start);
            if (cyc == exp_start) begin
                cur = q.pop_front();
                check("zchan",  zc.zcheck_global_channel, cur.ch);
                check("zscale", zc.zcheck_scale, cur.sc);
                if (delay < 0) begin
                    exp_sd  = cyc + tmo;
                    end_cyc = exp_sd;
                    exp_tmo = 1'b1;
                end else begin
                    done_at = cyc + ((delay == 0) ? int'($urandom_range(1, 12)) : delay);
                end
            end
            check("result_valid", result_valid, cyc == exp_rv);
            if (cyc == exp_rv) begin
                check("result_chan",  result_channel, cur.ch);
                check("result_scale", result_scale, cur.sc);
            end
            check("sweep_done",  sweep_done, cyc == exp_sd);
            check("busy",        busy, (end_cyc < 0) || (cyc < end_cyc));
            check("range_err",   range_err, 0);
            check("timeout_err", timeout_err, exp_tmo && (cyc >= end_cyc));

            zc.zcheck_done = (cyc == done_at) ||
                             (noise && (cyc == 0 || cyc == exp_start || cyc == done_at + 1));
            sweep_abort    = (cyc == abort_at);
            if (cyc == done_at) begin
                nxt    = cyc + ((settle > 1) ? settle : 1) + 2;
                exp_rv = cyc + 1;
                if (cur.ch == abort_ch[11:0] && abort_ch >= 0) begin
                    abort_at = cyc + 1;
                    end_cyc  = cyc + 2;
                end else if (q.size() == 0) begin
                    exp_sd  = nxt;
                    end_cyc = nxt;
                end else begin
                    exp_start = nxt;
                end
            end
            if (end_cyc >= 0 && cyc >= end_cyc + 12) break;
        end
        check("sweep_ended_in_budget", (end_cyc >= 0) && (cyc < 4000), 1);
        zc.zcheck_done = 1'b0;
        sweep_abort    = 1'b0;
    endtask

    task automatic range_case(input int first, input int last);
        @(negedge clk);
        first_channel = first[11:0];
        last_channel  = last[11:0];
        sweep_start   = 1'b1;
        @(posedge clk);
        #1;
        sweep_start = 1'b0;
        @(negedge clk);
        check("range_sweep_done", sweep_done, 1);
        check("range_err_set",    range_err, 1);
        check("range_busy",       busy, 0);
        check("range_zstart",     zc.zcheck_start, 0);
        @(negedge clk);
        check("range_done_single", sweep_done, 0);
        check("range_err_sticky",  range_err, 1);
        check("range_zstart2",     zc.zcheck_start, 0);
    endtask

    initial begin
        int f, l;
        rstn = 1'b0;
        sweep_start = 1'b0;
        sweep_abort = 1'b0;
        zc.zcheck_done = 1'b0;
        first_channel = '0;
        last_channel = '0;
        scale_cfg = '0;
        settle_cycles = '0;
        timeout_cycles = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("post_reset");

        run_sweep(4, 6, 3, 0, 2'b01, 10, -1, 1'b0);
        run_sweep(255, 255, 0, 0, 2'b10, 4, -1, 1'b1);
        range_case(10, 9);
        range_case(3, 256);
        run_sweep(0, 1, 1, 0, 2'b11, 0, -1, 1'b0);
        run_sweep(2, 3, 1, 50, 2'b00, -1, -1, 1'b0);
        run_sweep(3, 8, 4, 0, 2'b01, 0, 5, 1'b1);

        for (int i = 0; i < 6; i++) begin
            f = int'($urandom_range(0, 250));
            l = f + int'($urandom_range(0, 3));
            run_sweep(f, l, int'($urandom_range(0, 5)), ($urandom_range(0, 1) == 1) ? 200 : 0,
                      2'($urandom), 0, -1, 1'($urandom));
        end

        // Reset while the engine is being waited on.
        @(negedge clk);
        first_channel  = 12'd7;
        last_channel   = 12'd9;
        settle_cycles  = 16'd2;
        timeout_cycles = 24'd0;
        scale_cfg      = 2'b10;
        sweep_start    = 1'b1;
        @(posedge clk);
        #1;
        sweep_start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("reset_release");
        end
        run_sweep(7, 9, 2, 0, 2'b10, 0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
